// File: rtl/scan_sequencer_3b_pkg.sv
// Shared definitions for the 3-bit select scan engine: state encodings,
// code width/count and per-direction first/last codes.
package scan_sequencer_3b_pkg;

   localparam int CODE_W    = 3;
   localparam int NUM_CODES = 8;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PRESENT = 2'd1,
      ST_HOLD    = 2'd2,
      ST_DONE    = 2'd3
   } state_e;

   localparam logic [CODE_W-1:0] FIRST_UP = 3'd0;
   localparam logic [CODE_W-1:0] LAST_UP  = 3'd7;
   localparam logic [CODE_W-1:0] FIRST_DN = 3'd7;
   localparam logic [CODE_W-1:0] LAST_DN  = 3'd0;

   function automatic logic [CODE_W-1:0] first_code(input logic dir);
      return dir ? FIRST_DN : FIRST_UP;
   endfunction

   function automatic logic [CODE_W-1:0] last_code(input logic dir);
      return dir ? LAST_DN : LAST_UP;
   endfunction

   // Modulo-8 step; wrap comes for free from the 3-bit width.
   function automatic logic [CODE_W-1:0] step_code(input logic [CODE_W-1:0] code,
                                                   input logic dir);
      return dir ? code - 3'd1 : code + 3'd1;
   endfunction

endpackage

// File: rtl/scan_sequencer_3b_if.sv
// Select-code handshake toward the 3-to-8 decoder: code {a,b,c} (a = MSB)
// qualified by valid, accepted by ready.
interface scan_sequencer_3b_if;
   logic a;
   logic b;
   logic c;
   logic valid;
   logic ready;

   modport master (output a, output b, output c, output valid, input ready);
   modport slave  (input a, input b, input c, input valid, output ready);
endinterface

// File: rtl/scan_sequencer_3b_dwell.sv
// Loadable dwell down-counter; expire flags count == 1 so the caller can
// step on that edge. clr has priority over load, load over decrement.
module dwell_counter #(
   parameter int DWELL_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clr_i,
   input  logic               load_i,
   input  logic [DWELL_W-1:0] load_val_i,
   input  logic               dec_i,
   output logic               expire_o
);

   logic [DWELL_W-1:0] cnt_q;
   logic [DWELL_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - DWELL_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire_o = (cnt_q == DWELL_W'(1));

endmodule

// File: rtl/scan_sequencer_3b.sv
// Sweeps {a,b,c} through all eight codes with valid/ready and a dwell gap.
// SCAN_CONTINUOUS_EN: wrap forever until stop instead of a single sweep + done.
module scan_sequencer_3b
   import scan_sequencer_3b_pkg::*;
#(
   parameter int DWELL_W = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                stop,
   input  logic                dir,
   input  logic [DWELL_W-1:0]  dwell,
   output logic                busy,
   output logic                done,
   scan_sequencer_3b_if.master sel
);

   state_e              state_q, state_d;
   logic [CODE_W-1:0]   code_q,  code_d;
   logic                dir_q,   dir_d;
   logic [DWELL_W-1:0]  dwell_q, dwell_d;

   logic                cnt_clr;
   logic                cnt_load;
   logic                cnt_dec;
   logic                cnt_expire;
   logic [DWELL_W-1:0]  dwell_eff;

   assign dwell_eff = (dwell_q == '0) ? DWELL_W'(1) : dwell_q;

   dwell_counter #(.DWELL_W(DWELL_W)) u_dwell (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr_i      (cnt_clr),
      .load_i     (cnt_load),
      .load_val_i (dwell_eff),
      .dec_i      (cnt_dec),
      .expire_o   (cnt_expire)
   );

   always_comb begin
      state_d  = state_q;
      code_d   = code_q;
      dir_d    = dir_q;
      dwell_d  = dwell_q;
      cnt_clr  = 1'b0;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            code_d = '0;
            if (start && !stop) begin
               dir_d   = dir;
               dwell_d = dwell;
               code_d  = first_code(dir);
               state_d = ST_PRESENT;
            end
         end
         ST_PRESENT: begin
            // stop outranks a same-cycle handshake
            if (stop) begin
               state_d = ST_IDLE;
               code_d  = '0;
               cnt_clr = 1'b1;
            end else if (sel.ready) begin
`ifdef SCAN_CONTINUOUS_EN
               cnt_load = 1'b1;
               state_d  = ST_HOLD;
`else
               if (code_q == last_code(dir_q)) begin
                  state_d = ST_DONE;
               end else begin
                  cnt_load = 1'b1;
                  state_d  = ST_HOLD;
               end
`endif
            end
         end
         ST_HOLD: begin
            if (stop) begin
               state_d = ST_IDLE;
               code_d  = '0;
               cnt_clr = 1'b1;
            end else begin
               cnt_dec = 1'b1;
               if (cnt_expire) begin
                  code_d  = step_code(code_q, dir_q);
                  state_d = ST_PRESENT;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            code_d  = '0;
         end
         default: begin
            state_d = ST_IDLE;
            code_d  = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         code_q  <= '0;
         dir_q   <= 1'b0;
         dwell_q <= '0;
      end else begin
         state_q <= state_d;
         code_q  <= code_d;
         dir_q   <= dir_d;
         dwell_q <= dwell_d;
      end
   end

   assign sel.valid = (state_q == ST_PRESENT);
   assign sel.a     = code_q[2];
   assign sel.b     = code_q[1];
   assign sel.c     = code_q[0];
   assign busy      = (state_q == ST_PRESENT) || (state_q == ST_HOLD);
   assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_scan_sequencer_3b.sv
// Directed bench for scan_sequencer_3b: per-cycle vector table plus
// hand-sequenced full sweeps, async reset and (optionally) continuous wrap.
module tb_scan_sequencer_3b;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic       dir = 1'b0;
   logic [7:0] dwell = 8'd0;
   logic       busy;
   logic       done;

   int n_checks = 0;
   int n_fail   = 0;

   scan_sequencer_3b_if sel_if ();

   scan_sequencer_3b #(.DWELL_W(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .stop  (stop),
      .dir   (dir),
      .dwell (dwell),
      .busy  (busy),
      .done  (done),
      .sel   (sel_if)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       start;
      logic       stop;
      logic       dir;
      logic [7:0] dwell;
      logic       ready;
      logic       exp_valid;
      logic [2:0] exp_code;
      logic       exp_busy;
      logic       exp_done;
   } vec_t;

   vec_t vecs[18];

   function automatic vec_t mk(input logic st, input logic sp, input logic d,
                               input logic [7:0] dw, input logic rdy,
                               input logic ev, input logic [2:0] ec,
                               input logic eb, input logic ed);
      vec_t v;
      v.start = st; v.stop = sp; v.dir = d; v.dwell = dw; v.ready = rdy;
      v.exp_valid = ev; v.exp_code = ec; v.exp_busy = eb; v.exp_done = ed;
      return v;
   endfunction

   function automatic logic [2:0] code_now();
      return {sel_if.a, sel_if.b, sel_if.c};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string nm, input logic ev, input logic [2:0] ec,
                          input logic eb, input logic ed);
      chk({nm, ".valid"}, 32'(sel_if.valid), 32'(ev));
      chk({nm, ".code"},  32'(code_now()),   32'(ec));
      chk({nm, ".busy"},  32'(busy),         32'(eb));
      chk({nm, ".done"},  32'(done),         32'(ed));
   endtask

   // Full sweep with ready held high; checks every cycle and the edge of the final handshake.
   task automatic sweep(input logic d, input int dw, input int nhs, input bit expect_done);
      int         dd;
      int         edge_n;
      logic [2:0] code;
      dd = (dw == 0) ? 1 : dw;
      start = 1'b1; stop = 1'b0; dir = d; dwell = 8'(dw); sel_if.ready = 1'b1;
      tick();
      edge_n = 0;
      start = 1'b0;
      code  = d ? 3'd7 : 3'd0;
      for (int hs = 0; hs < nhs; hs++) begin
         chk_out($sformatf("sweep%0d_hs%0d_present", d, hs), 1'b1, code, 1'b1, 1'b0);
         tick();
         edge_n++;
         if (expect_done && hs == nhs - 1) begin
            chk("sweep_done", 32'(done), 32'd1);
            chk("sweep_done_valid", 32'(sel_if.valid), 32'd0);
            chk("sweep_done_busy", 32'(busy), 32'd0);
            chk("sweep_done_edge", 32'(edge_n), 32'(1 + 7 * (dd + 1)));
            tick();
            chk_out("sweep_idle", 1'b0, 3'd0, 1'b0, 1'b0);
         end else begin
            for (int j = 0; j < dd; j++) begin
               chk($sformatf("sweep_hold_valid_%0d_%0d", hs, j), 32'(sel_if.valid), 32'd0);
               chk("sweep_hold_done", 32'(done), 32'd0);
               tick();
               edge_n++;
            end
            code = d ? code - 3'd1 : code + 3'd1;
         end
      end
   endtask

   initial begin
      bit found;
      sel_if.ready = 1'b0;
      #2;
      chk_out("reset", 1'b0, 3'd0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      //            st sp d  dwell  rdy | val code busy done
      vecs[0]  = mk(1, 1, 0, 8'd1, 0,   0, 3'd0, 0, 0);
      vecs[1]  = mk(0, 0, 0, 8'd1, 1,   0, 3'd0, 0, 0);
      vecs[2]  = mk(1, 0, 0, 8'd1, 0,   1, 3'd0, 1, 0);
      vecs[3]  = mk(0, 0, 0, 8'd1, 1,   0, 3'd0, 1, 0);
      vecs[4]  = mk(0, 0, 0, 8'd1, 1,   1, 3'd1, 1, 0);
      vecs[5]  = mk(0, 0, 0, 8'd1, 1,   0, 3'd1, 1, 0);
      vecs[6]  = mk(0, 0, 0, 8'd1, 0,   1, 3'd2, 1, 0);
      vecs[7]  = mk(1, 0, 1, 8'd5, 0,   1, 3'd2, 1, 0);
      vecs[8]  = mk(0, 0, 0, 8'd1, 0,   1, 3'd2, 1, 0);
      vecs[9]  = mk(0, 0, 0, 8'd1, 0,   1, 3'd2, 1, 0);
      vecs[10] = mk(0, 0, 0, 8'd1, 1,   0, 3'd2, 1, 0);
      vecs[11] = mk(0, 0, 1, 8'd1, 1,   1, 3'd3, 1, 0);
      vecs[12] = mk(0, 0, 0, 8'd1, 1,   0, 3'd3, 1, 0);
      vecs[13] = mk(0, 1, 0, 8'd1, 1,   0, 3'd0, 0, 0);
      vecs[14] = mk(0, 0, 0, 8'd1, 1,   0, 3'd0, 0, 0);
      vecs[15] = mk(1, 0, 1, 8'd0, 0,   1, 3'd7, 1, 0);
      vecs[16] = mk(0, 1, 1, 8'd0, 1,   0, 3'd0, 0, 0);
      vecs[17] = mk(0, 0, 0, 8'd1, 0,   0, 3'd0, 0, 0);

      for (int i = 0; i < 18; i++) begin
         start = vecs[i].start; stop = vecs[i].stop; dir = vecs[i].dir;
         dwell = vecs[i].dwell; sel_if.ready = vecs[i].ready;
         tick();
         chk_out($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_code,
                 vecs[i].exp_busy, vecs[i].exp_done);
      end
      stop = 1'b0; start = 1'b0;

`ifdef SCAN_CONTINUOUS_EN
      sweep(1'b0, 2, 24, 1'b0);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      chk_out("cont_stop", 1'b0, 3'd0, 1'b0, 1'b0);
`else
      sweep(1'b0, 4, 8, 1'b1);
      sweep(1'b1, 0, 8, 1'b1);
`endif

      // Async reset while holding after code 101.
      start = 1'b1; dir = 1'b0; dwell = 8'd3; sel_if.ready = 1'b1;
      tick();
      start = 1'b0;
      found = 1'b0;
      for (int t = 0; t < 100 && !found; t++) begin
         if (!sel_if.valid && busy && code_now() == 3'd5) found = 1'b1;
         else tick();
      end
      chk("reset_search_found", 32'(found), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk_out("async_reset", 1'b0, 3'd0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk_out("post_reset_idle", 1'b0, 3'd0, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
